if_id_stage: RTL and testbench



---
 rtl/if_id_stage_pkg.sv | 23 ++
 rtl/if_id_stage_hazard_detect.sv | 22 ++
 rtl/if_id_stage.sv | 113 +++++++++++
 tb/tb_if_id_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared constants, opcodes and fetch-control state encoding for the IF/ID slice.
// Purely declarative: no logic, no latency, no flow control.
package if_id_stage_pkg;

  localparam logic [5:0]  OP_J         = 6'b000010;
  localparam logic [5:0]  OP_JAL       = 6'b000011;
  localparam logic [5:0]  OP_LW        = 6'b100011;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // Records the action taken by the IF/ID register in the previous cycle.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Combinational j/jal decode and load-use hazard check of the ID instruction against EX.
// Zero latency; no state and no flow control of its own.
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       valid,
  input  logic       mem_read_ex,
  input  logic [4:0] rt_ex,
  output logic       is_j,
  output logic       hazard
);

  assign is_j = valid && is_jump_op(op);

  // Both source fields are compared for every format; a spurious I-type stall is harmless.
  assign hazard = mem_read_ex && (rt_ex != 5'd0) && valid && !is_j &&
                  ((rt_ex == rs) || (rt_ex == rt));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID register and fetch control: 1-cycle register, stalls fetch (PCWrite=0) for one cycle on load-use.
// Branch/jump redirect flushes the slot to NOP; IFID_PERF_CNT_EN adds stall/flush counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_IF,
  input  logic [31:0] PC_4_IF,
  input  logic        memRead_EX,
  input  logic [4:0]  rt_EX,
  input  logic        brTaken_EX,
  output logic [31:0] instr_ID,
  output logic [31:0] PC_4_ID,
  output logic [31:0] PC_last,
  output logic        valid_ID,
  output logic        jSig_ID,
  output logic        PCWrite,
  output logic        bubble_EX
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  state_t state_q, state_d;
  logic   is_j, hazard;
  logic   ld_fetch, ld_nop;

  hazard_detect u_hazard_detect (
    .op          (instr_ID[31:26]),
    .rs          (instr_ID[25:21]),
    .rt          (instr_ID[20:16]),
    .valid       (valid_ID),
    .mem_read_ex (memRead_EX),
    .rt_ex       (rt_EX),
    .is_j        (is_j),
    .hazard      (hazard)
  );

  always_comb begin
    state_d   = ST_RUN;
    ld_fetch  = 1'b1;
    ld_nop    = 1'b0;
    PCWrite   = 1'b1;
    bubble_EX = 1'b0;
    jSig_ID   = 1'b0;
    if (reset) begin
      state_d  = ST_INIT;
      ld_fetch = 1'b0;
    end else begin
      jSig_ID = is_j;
      if (brTaken_EX) begin
        ld_nop    = 1'b1;
        ld_fetch  = 1'b0;
        bubble_EX = 1'b1;
        state_d   = ST_FLUSH;
      end else if (state_q == ST_INIT) begin
        state_d = ST_RUN;
      end else if (is_j) begin
        // No delay slot: the word fetched alongside the jump is wrong-path.
        ld_nop   = 1'b1;
        ld_fetch = 1'b0;
        state_d  = ST_FLUSH;
      end else if (hazard) begin
        ld_fetch  = 1'b0;
        PCWrite   = 1'b0;
        bubble_EX = 1'b1;
        state_d   = ST_STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_ID <= NOP;
      PC_4_ID  <= RESET_PC + 32'd4;
      valid_ID <= 1'b0;
      state_q  <= ST_INIT;
    end else begin
      state_q <= state_d;
      if (ld_nop) begin
        // PC_4 keeps tracking the fetch stream so PC_last stays meaningful in a bubble.
        instr_ID <= NOP;
        PC_4_ID  <= PC_4_IF;
        valid_ID <= 1'b0;
      end else if (ld_fetch) begin
        instr_ID <= instr_IF;
        PC_4_ID  <= PC_4_IF;
        valid_ID <= 1'b1;
      end
    end
  end

  assign PC_last = PC_4_ID - 32'd4;

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (hazard && !brTaken_EX) stall_cnt <= stall_cnt + 32'd1;
      if (ld_nop)                flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed plus random stimulus for if_id_stage against a slot-level reference model.
// Inputs change 1ns after the rising edge; outputs are compared 2ns after it.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_IF, PC_4_IF;
  logic        memRead_EX, brTaken_EX;
  logic [4:0]  rt_EX;
  logic [31:0] instr_ID, PC_4_ID, PC_last;
  logic        valid_ID, jSig_ID, PCWrite, bubble_EX;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the ID slot and event counts.
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  int unsigned m_stalls, m_flushes;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk        (clk),
    .reset      (reset),
    .instr_IF   (instr_IF),
    .PC_4_IF    (PC_4_IF),
    .memRead_EX (memRead_EX),
    .rt_EX      (rt_EX),
    .brTaken_EX (brTaken_EX),
    .instr_ID   (instr_ID),
    .PC_4_ID    (PC_4_ID),
    .PC_last    (PC_last),
    .valid_ID   (valid_ID),
    .jSig_ID    (jSig_ID),
    .PCWrite    (PCWrite),
    .bubble_EX  (bubble_EX)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_is_jump();
    return m_valid && (m_instr[31:26] == 6'd2 || m_instr[31:26] == 6'd3);
  endfunction

  function automatic logic ref_load_use();
    logic [4:0] rs, rt;
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    return memRead_EX && rt_EX != 0 && m_valid && !ref_is_jump() &&
           (rt_EX == rs || rt_EX == rt);
  endfunction

  task automatic check_all(input string tag);
    logic j, h;
    j = ref_is_jump();
    h = ref_load_use();
    chk({tag, ".instr_ID"}, instr_ID, m_instr);
    chk({tag, ".PC_4_ID"}, PC_4_ID, m_pc4);
    chk({tag, ".PC_last"}, PC_last, m_pc4 - 32'd4);
    chk({tag, ".valid_ID"}, {31'd0, valid_ID}, {31'd0, m_valid});
    chk({tag, ".jSig_ID"}, {31'd0, jSig_ID}, {31'd0, !reset && j});
    chk({tag, ".PCWrite"}, {31'd0, PCWrite}, {31'd0, reset || brTaken_EX || j || !h});
    chk({tag, ".bubble_EX"}, {31'd0, bubble_EX},
        {31'd0, !reset && (brTaken_EX || (!j && h))});
`ifdef IFID_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_stalls);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flushes);
`endif
  endtask

  // Advance one clock, updating the model from the inputs currently applied.
  task automatic tick();
    logic j, h;
    j = ref_is_jump();
    h = ref_load_use();
    @(posedge clk);
    if (reset) begin
      m_instr = 32'h0; m_pc4 = 32'h3004; m_valid = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else if (brTaken_EX || j) begin
      m_instr = 32'h0; m_pc4 = PC_4_IF; m_valid = 1'b0;
      m_flushes++;
    end else if (h) begin
      m_stalls++;
    end else begin
      m_instr = instr_IF; m_pc4 = PC_4_IF; m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic mr, input logic [4:0] rt, input logic br);
    reset = rst; instr_IF = ins; PC_4_IF = pc4;
    memRead_EX = mr; rt_EX = rt; brTaken_EX = br;
    #1;
  endtask

  initial begin
    m_instr = 32'h0; m_pc4 = 32'h3004; m_valid = 1'b0;
    m_stalls = 0; m_flushes = 0;
    drive(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst.PCWrite", {31'd0, PCWrite}, 32'd1);
    check_all("rst");

    // INIT cycle, then the first fetched word lands in ID.
    drive(1'b0, 32'h8C08_0000, 32'h3004, 1'b0, 5'd0, 1'b0);
    check_all("init");
    tick();
    chk("first.instr", instr_ID, 32'h8C08_0000);
    chk("first.pc_last", PC_last, 32'h3000);
    chk("first.valid", {31'd0, valid_ID}, 32'd1);

    // add $10,$8,$9 into ID, then a lw to $8 sits in EX.
    drive(1'b0, 32'h0109_5020, 32'h3008, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 32'h2129_0001, 32'h300C, 1'b1, 5'd8, 1'b0);
    chk("lu.PCWrite", {31'd0, PCWrite}, 32'd0);
    chk("lu.bubble", {31'd0, bubble_EX}, 32'd1);
    check_all("lu");
    tick();
    chk("lu.hold", instr_ID, 32'h0109_5020);
    drive(1'b0, 32'h2129_0001, 32'h300C, 1'b0, 5'd0, 1'b0);
    check_all("lu_clear");
    tick();
    chk("lu.resume", instr_ID, 32'h2129_0001);

    // Load to $zero never stalls.
    drive(1'b0, 32'h0800_0C00, 32'h3010, 1'b1, 5'd0, 1'b0);
    chk("rt0.PCWrite", {31'd0, PCWrite}, 32'd1);
    check_all("rt0");
    tick();

    // Jump in ID: no stall even when a load is in EX, next slot is flushed.
    drive(1'b0, 32'h1234_5678, 32'h3014, 1'b1, 5'd0, 1'b0);
    chk("j.jSig", {31'd0, jSig_ID}, 32'd1);
    chk("j.PCWrite", {31'd0, PCWrite}, 32'd1);
    check_all("j");
    tick();
    chk("j.flush", instr_ID, 32'h0);
    chk("j.valid", {31'd0, valid_ID}, 32'd0);

    // Branch redirect together with a load-use hazard.
    drive(1'b0, 32'h0109_5020, 32'h3030, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 32'hAAAA_5555, 32'h3034, 1'b1, 5'd9, 1'b1);
    chk("br.PCWrite", {31'd0, PCWrite}, 32'd1);
    chk("br.bubble", {31'd0, bubble_EX}, 32'd1);
    check_all("br");
    tick();
    check_all("br_after");

    // Reset asserted in the middle of a stall.
    drive(1'b0, 32'h0109_5020, 32'h3040, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h3044, 1'b1, 5'd9, 1'b0);
    tick();
    drive(1'b1, 32'h0, 32'h3044, 1'b1, 5'd9, 1'b0);
    check_all("rst_stall");
    tick();
    chk("rst_stall.valid", {31'd0, valid_ID}, 32'd0);
    chk("rst_stall.instr", instr_ID, 32'h0);
    chk("rst_stall.pc_last", PC_last, 32'h3000);
    chk("rst_stall.PCWrite", {31'd0, PCWrite}, 32'd1);

    // Random traffic biased toward jumps, loads and matching register fields.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      logic [4:0]  rt;
      logic [5:0]  ops [6];
      ops = '{6'h00, 6'h23, 6'h02, 6'h03, 6'h04, 6'h08};
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0: rt = m_instr[25:21];
        1: rt = m_instr[20:16];
        2: rt = 5'd0;
        default: rt = 5'($urandom);
      endcase
      drive($urandom_range(0, 49) == 0, ins, $urandom,
            $urandom_range(0, 1) == 1, rt, $urandom_range(0, 9) == 0);
      check_all("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
